// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: two-entry elastic pipeline register (main + skid).
//
// Sits between two pipeline stages. The upstream side uses valid/ready; the
// downstream side sees registered out_valid/out_data. in_ready depends only on
// registered state and rst, so a downstream stall never reaches upstream
// combinationally. The skid entry absorbs the one beat that can arrive in the
// cycle the downstream stalls.
//
// Optional feature: define PIPE_FLUSH_EN to add the flush port. A flush drops
// both entries (data regs are kept) and has lower priority than rst.
//
// Ports:
//   clk        clock, all state updates on posedge
//   rst        synchronous active-high reset
//   in_valid   upstream beat present
//   in_data    upstream payload [N-1:0]
//   in_ready   block can accept a beat this cycle
//   out_valid  payload on out_data is valid
//   out_data   payload to downstream stage [N-1:0]
//   out_ready  downstream accepts beat this cycle
//   flush      (PIPE_FLUSH_EN only) discard all held beats
module pipe_skid_reg #(
  parameter int unsigned N = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [N-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [N-1:0] out_data,
`ifdef PIPE_FLUSH_EN
  input  logic         flush,
`endif
  input  logic         out_ready
);

  // Occupancy states; the valid bits are derived from the state.
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StFull  = 2'd1,
    StSkid  = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   main_data_q;
  logic [N-1:0]   skid_data_q;

  logic           main_valid;
  logic           skid_valid;
  logic           in_fire;
  logic           out_fire;
  logic           main_we;
  logic           main_from_skid;
  logic           skid_we;

  assign main_valid = (state_q == StFull) || (state_q == StSkid);
  assign skid_valid = (state_q == StSkid);

  assign out_valid = main_valid;
  assign out_data  = main_data_q;
  assign in_ready  = ~skid_valid & ~rst;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_comb begin
    state_d        = state_q;
    main_we        = 1'b0;
    main_from_skid = 1'b0;
    skid_we        = 1'b0;
    case (state_q)
      StEmpty: begin
        if (in_fire) begin
          state_d = StFull;
          main_we = 1'b1;
        end
      end
      StFull: begin
        if (in_fire && out_fire) begin
          main_we = 1'b1;
        end else if (in_fire) begin
          // Downstream stalled: park the new beat behind the current one.
          state_d = StSkid;
          skid_we = 1'b1;
        end else if (out_fire) begin
          state_d = StEmpty;
        end
      end
      StSkid: begin
        if (out_fire) begin
          state_d        = StFull;
          main_we        = 1'b1;
          main_from_skid = 1'b1;
        end
      end
      default: state_d = StEmpty;
    endcase
`ifdef PIPE_FLUSH_EN
    // Data writes still happen; only occupancy is dropped, so any beat
    // accepted this cycle is discarded.
    if (flush) begin
      state_d = StEmpty;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StEmpty;
      main_data_q <= '0;
      skid_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (main_we) begin
        main_data_q <= main_from_skid ? skid_data_q : in_data;
      end
      if (skid_we) begin
        skid_data_q <= in_data;
      end
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Testbench for pipe_skid_reg: directed vector table, a random scoreboard
// stream, and (with PIPE_FLUSH_EN) flush sequences.
module tb_pipe_skid_reg;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [63:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [63:0] out_data;
  logic        out_ready;
  logic        flush;

  int checks;
  int failures;

  pipe_skid_reg #(.N(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
`ifdef PIPE_FLUSH_EN
    .flush     (flush),
`endif
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        iv;
    logic [63:0] d;
    logic        ordy;
    logic        e_ov;
    logic [63:0] e_od;
    logic        e_ir;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Drive inputs on negedge, check outputs #1 after the following posedge.
  task automatic step(input logic r, input logic iv, input logic [63:0] d, input logic ordy,
                      input logic fl);
    @(negedge clk);
    rst       = r;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string name, input logic ov, input logic [63:0] od,
                         input logic ir);
    chk({name, ".out_valid"}, {63'd0, out_valid}, {63'd0, ov});
    chk({name, ".out_data"}, out_data, od);
    chk({name, ".in_ready"}, {63'd0, in_ready}, {63'd0, ir});
  endtask

  logic [63:0] sb [$];
  logic        in_fire, out_fire;
  logic        prev_stall;
  logic [63:0] prev_data;
  logic [63:0] exp_d;
  int          drain;

  initial begin
    checks   = 0;
    failures = 0;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;

    //          rst   iv    d       ordy  e_ov  e_od    e_ir
    vecs[0]  = '{1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0}; // reset
    vecs[1]  = '{1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 64'h0, 1'b1}; // first post-reset
    vecs[3]  = '{1'b0, 1'b1, 64'hA, 1'b1, 1'b1, 64'hA, 1'b1}; // stream A,B,C
    vecs[4]  = '{1'b0, 1'b1, 64'hB, 1'b1, 1'b1, 64'hB, 1'b1};
    vecs[5]  = '{1'b0, 1'b1, 64'hC, 1'b1, 1'b1, 64'hC, 1'b1};
    vecs[6]  = '{1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 64'hC, 1'b1}; // empty, data held
    vecs[7]  = '{1'b0, 1'b1, 64'hA, 1'b0, 1'b1, 64'hA, 1'b1}; // FULL(A)
    vecs[8]  = '{1'b0, 1'b1, 64'hB, 1'b0, 1'b1, 64'hA, 1'b0}; // SKID
    vecs[9]  = '{1'b0, 1'b1, 64'hB, 1'b0, 1'b1, 64'hA, 1'b0}; // hold in SKID
    vecs[10] = '{1'b0, 1'b0, 64'h0, 1'b1, 1'b1, 64'hB, 1'b1}; // A taken
    vecs[11] = '{1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 64'hB, 1'b1}; // B taken
    vecs[12] = '{1'b0, 1'b1, 64'hA, 1'b0, 1'b1, 64'hA, 1'b1}; // refill
    vecs[13] = '{1'b0, 1'b1, 64'hB, 1'b0, 1'b1, 64'hA, 1'b0}; // SKID
    vecs[14] = '{1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0}; // rst mid-SKID
    vecs[15] = '{1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 64'h0, 1'b1};
    vecs[16] = '{1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 64'h0, 1'b1}; // A,B gone

    for (int i = 0; i < NV; i++) begin
      step(vecs[i].rst, vecs[i].iv, vecs[i].d, vecs[i].ordy, 1'b0);
      chk_out($sformatf("vec%0d", i), vecs[i].e_ov, vecs[i].e_od, vecs[i].e_ir);
    end

    // Random stream against a FIFO scoreboard.
    void'($urandom(1));
    prev_stall = 1'b0;
    prev_data  = '0;
    @(negedge clk);
    for (int c = 0; c < 10000; c++) begin
      if (prev_stall) begin
        chk("stall_valid", {63'd0, out_valid}, 64'd1);
        chk("stall_data", out_data, prev_data);
      end
      // Keep a refused beat stable until it is accepted.
      if (!(in_valid && !in_ready)) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = {$urandom, $urandom};
      end
      out_ready = 1'($urandom_range(0, 1));
      #1;
      in_fire    = in_valid & in_ready;
      out_fire   = out_valid & out_ready;
      prev_stall = out_valid & ~out_ready;
      prev_data  = out_data;
      if (out_fire) begin
        if (sb.size() == 0) begin
          chk("rand_extra_beat", out_data, 64'hDEAD);
        end else begin
          exp_d = sb.pop_front();
          chk("rand_order", out_data, exp_d);
        end
      end
      if (in_fire) sb.push_back(in_data);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain = 0;
    while (drain < 10) begin
      #1;
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("drain_extra_beat", out_data, 64'hDEAD);
        end else begin
          exp_d = sb.pop_front();
          chk("drain_order", out_data, exp_d);
        end
      end
      @(negedge clk);
      drain++;
    end
    chk("drain_left", 64'(sb.size()), 64'd0);
    chk("drain_empty", {63'd0, out_valid}, 64'd0);

`ifdef PIPE_FLUSH_EN
    step(1'b1, 1'b0, 64'h0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 64'hA, 1'b0, 1'b0);
    step(1'b0, 1'b1, 64'hB, 1'b0, 1'b0);
    chk_out("fl_skid", 1'b1, 64'hA, 1'b0);
    step(1'b0, 1'b0, 64'h0, 1'b0, 1'b1);
    chk("fl_empty.out_valid", {63'd0, out_valid}, 64'd0);
    chk("fl_empty.in_ready", {63'd0, in_ready}, 64'd1);
    step(1'b0, 1'b1, 64'hA, 1'b0, 1'b0);
    chk_out("fl_full", 1'b1, 64'hA, 1'b1);
    step(1'b0, 1'b1, 64'hD, 1'b0, 1'b1); // D accepted alongside flush
    chk("fl_d.out_valid", {63'd0, out_valid}, 64'd0);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
      chk($sformatf("fl_d_gone%0d", k), {63'd0, out_valid}, 64'd0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit so the bench can never hang.
  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
